camera_capture: RTL and testbench

Camera capture stage that sits directly downstream of the OV7670-style pixel source (real camera or the frame simulator). It samples the VSYNC/HREF/DATA byte stream and assembles each two-byte RGB444 pixel into one RGB332 byte. It writes that byte into the 176x144 frame-buffer RAM, and once per frame it reports a red/blue colour-majority result to the treasure-detection logic.

---
 rtl/camera_capture.sv | 128 ++++++++++++
 tb/tb_camera_capture.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/camera_capture.sv
// OV7670-style capture: packs RGB444 byte pairs into RGB332 frame-buffer writes
// and reports a per-frame red/blue colour-majority result.
module camera_capture #(
  parameter int          WIDTH      = 176,
  parameter int          HEIGHT     = 144,
  parameter logic [3:0]  COLOR_MIN  = 4'd8,
  parameter logic [14:0] PIX_THRESH = 15'd4000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VSYNC,
  input  logic        HREF,
  input  logic [7:0]  DATA,
  output logic        W_EN,
  output logic [14:0] WRITE_ADDRESS,
  output logic [7:0]  PIXEL_DATA,
  output logic        FRAME_DONE,
  output logic [14:0] RED_COUNT,
  output logic [14:0] BLUE_COUNT,
  output logic [1:0]  COLOR_RESULT
);

  localparam logic [1:0] WAIT_VS  = 2'd0;
  localparam logic [1:0] WAIT_END = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;

  localparam logic [7:0]  W8    = 8'(WIDTH);
  localparam logic [7:0]  H8    = 8'(HEIGHT);
  localparam logic [7:0]  H8M1  = 8'(HEIGHT - 1);
  localparam logic [14:0] W15   = 15'(WIDTH);
  localparam logic [14:0] CNT_MAX = 15'h7fff;

  logic [1:0]  state;
  logic [7:0]  x, y;
  logic [14:0] row_base;
  logic        phase, href_prev, line_seen;
  logic [3:0]  r_nib;
  logic [14:0] red_cnt, blue_cnt;

  logic [3:0] g_nib, b_nib;
  logic       is_red, is_blue, in_frame;
  logic [1:0] result;

  assign g_nib    = DATA[7:4];
  assign b_nib    = DATA[3:0];
  assign is_red   = (r_nib > g_nib) && (r_nib > b_nib) && (r_nib >= COLOR_MIN);
  assign is_blue  = (b_nib > r_nib) && (b_nib > g_nib) && (b_nib >= COLOR_MIN);
  assign in_frame = (x < W8) && (y < H8);

  always_comb begin
    result = 2'b00;
    if (red_cnt >= PIX_THRESH && red_cnt > blue_cnt)        result = 2'b01;
    else if (blue_cnt >= PIX_THRESH && blue_cnt > red_cnt)  result = 2'b10;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state         <= WAIT_VS;
      x             <= '0;
      y             <= '0;
      row_base      <= '0;
      phase         <= 1'b0;
      href_prev     <= 1'b0;
      line_seen     <= 1'b0;
      r_nib         <= '0;
      red_cnt       <= '0;
      blue_cnt      <= '0;
      W_EN          <= 1'b0;
      WRITE_ADDRESS <= '0;
      PIXEL_DATA    <= '0;
      FRAME_DONE    <= 1'b0;
      RED_COUNT     <= '0;
      BLUE_COUNT    <= '0;
      COLOR_RESULT  <= '0;
    end else begin
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      href_prev  <= HREF;
      case (state)
        WAIT_VS:  if (VSYNC)  state <= WAIT_END;
        WAIT_END: if (!VSYNC) state <= ACTIVE;
        ACTIVE: begin
          if (VSYNC) begin
            // frame end wins over any byte sampled in the same cycle
            FRAME_DONE   <= 1'b1;
            RED_COUNT    <= red_cnt;
            BLUE_COUNT   <= blue_cnt;
            COLOR_RESULT <= result;
            red_cnt      <= '0;
            blue_cnt     <= '0;
            x            <= '0;
            y            <= '0;
            row_base     <= '0;
            phase        <= 1'b0;
            line_seen    <= 1'b0;
            state        <= WAIT_END;
          end else if (HREF) begin
            line_seen <= 1'b1;
            phase     <= ~phase;
            if (!phase) begin
              r_nib <= DATA[3:0];
            end else begin
              if (in_frame) begin
                W_EN          <= 1'b1;
                WRITE_ADDRESS <= row_base + {7'd0, x};
                PIXEL_DATA    <= {r_nib[3:1], g_nib[3:1], b_nib[3:2]};
                if (is_red && red_cnt != CNT_MAX)   red_cnt  <= red_cnt + 15'd1;
                if (is_blue && blue_cnt != CNT_MAX) blue_cnt <= blue_cnt + 15'd1;
              end
              if (x < W8) x <= x + 8'd1;
            end
          end else if (href_prev) begin
            // line end: a trailing odd byte is simply dropped with the phase reset
            x         <= '0;
            phase     <= 1'b0;
            line_seen <= 1'b0;
            if (line_seen) begin
              if (y < H8)   y        <= y + 8'd1;
              if (y < H8M1) row_base <= row_base + W15;
            end
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture on a reduced 16x6 geometry.
module tb_camera_capture;
  localparam int W = 16;
  localparam int H = 6;

  logic        CLK = 1'b0, RESET_N = 1'b0, VSYNC = 1'b0, HREF = 1'b0;
  logic [7:0]  DATA = 8'h00;
  logic        W_EN, FRAME_DONE;
  logic [14:0] WRITE_ADDRESS, RED_COUNT, BLUE_COUNT;
  logic [7:0]  PIXEL_DATA;
  logic [1:0]  COLOR_RESULT;

  always #5 CLK = ~CLK;

  camera_capture #(.WIDTH(W), .HEIGHT(H), .COLOR_MIN(4'd8), .PIX_THRESH(15'd48)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
    .W_EN(W_EN), .WRITE_ADDRESS(WRITE_ADDRESS), .PIXEL_DATA(PIXEL_DATA),
    .FRAME_DONE(FRAME_DONE), .RED_COUNT(RED_COUNT), .BLUE_COUNT(BLUE_COUNT),
    .COLOR_RESULT(COLOR_RESULT)
  );

  int vec = 0, bad = 0;
  logic [22:0] wq[$];   // {addr, pixel}
  logic [31:0] fq[$];   // {red, blue, result}
  logic        fd_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic mon();
    logic [22:0] ew;
    logic [31:0] ef;
    if (W_EN) begin
      if (wq.size() == 0) chk("unexpected_write", {9'd0, WRITE_ADDRESS, PIXEL_DATA}, 32'hffffffff);
      else begin
        ew = wq.pop_front();
        chk("write_addr_pixel", {9'd0, WRITE_ADDRESS, PIXEL_DATA}, {9'd0, ew});
      end
    end
    if (FRAME_DONE) begin
      if (fd_prev) chk("frame_done_pulse", 32'd1, 32'd0);
      if (fq.size() == 0) chk("unexpected_frame_done", {RED_COUNT, BLUE_COUNT, COLOR_RESULT}, 32'hffffffff);
      else begin
        ef = fq.pop_front();
        chk("frame_result", {RED_COUNT, BLUE_COUNT, COLOR_RESULT}, ef);
      end
    end
    fd_prev = FRAME_DONE;
  endtask

  task automatic vs(input bit exp_done, input logic [14:0] r, input logic [14:0] b, input logic [1:0] res);
    if (exp_done) fq.push_back({r, b, res});
    @(negedge CLK) VSYNC = 1'b1;
    repeat (3) @(negedge CLK);
    VSYNC = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic pix(input logic [11:0] c, input logic [7:0] eb, input bit push, input logic [14:0] addr);
    @(negedge CLK) begin HREF = 1'b1; DATA = {4'hA, c[11:8]}; end
    @(negedge CLK) DATA = c[7:0];
    if (push) wq.push_back({addr, eb});
  endtask

  // mode 0 uniform a; 1: b where x<split; 2: b inside radius-2 circle at (8,3)
  task automatic frame(input int mode, input int split,
                       input logic [11:0] ca, input logic [7:0] ba,
                       input logic [11:0] cb, input logic [7:0] bb,
                       input int l0, input int l1, input bit long_line, input bit en);
    for (int l = l0; l < l1; l++) begin
      int np;
      np = (long_line && l == 0) ? W + 5 : W;
      for (int i = 0; i < np; i++) begin
        bit use_b;
        case (mode)
          1:       use_b = (i < split);
          2:       use_b = ((i - 8) * (i - 8) + (l - 3) * (l - 3)) <= 4;
          default: use_b = 1'b0;
        endcase
        pix(use_b ? cb : ca, use_b ? bb : ba, en && i < W && l < H, 15'(l * W + i));
      end
      if (long_line && l == 0) @(negedge CLK) DATA = {4'hA, ca[11:8]};
      @(negedge CLK) begin HREF = 1'b0; DATA = 8'h00; end
      repeat (3) @(negedge CLK);
    end
  endtask

  task automatic chk_zero(input string when_s);
    chk({when_s, "_w_en"}, {31'd0, W_EN}, 32'd0);
    chk({when_s, "_addr"}, {17'd0, WRITE_ADDRESS}, 32'd0);
    chk({when_s, "_pixel"}, {24'd0, PIXEL_DATA}, 32'd0);
    chk({when_s, "_frame_done"}, {31'd0, FRAME_DONE}, 32'd0);
    chk({when_s, "_red"}, {17'd0, RED_COUNT}, 32'd0);
    chk({when_s, "_blue"}, {17'd0, BLUE_COUNT}, 32'd0);
    chk({when_s, "_result"}, {30'd0, COLOR_RESULT}, 32'd0);
  endtask

  initial begin
    fork
      forever begin
        @(posedge CLK);
        #1;
        mon();
      end
    join_none

    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RESET_N = 1'b1;

    vs(0, 0, 0, 2'b00);
    // yellow circle on cyan: neither colour dominates
    frame(2, 0, 12'h0FF, 8'h1F, 12'hFF0, 8'hFC, 0, H, 0, 1);
    vs(1, 15'd0, 15'd0, 2'b00);
    // full red
    frame(0, 0, 12'hF00, 8'hE0, 12'h000, 8'h00, 0, H, 0, 1);
    vs(1, 15'd96, 15'd0, 2'b01);
    // blue x<10, red elsewhere: 60 blue, 36 red
    frame(1, 10, 12'hF00, 8'hE0, 12'h00F, 8'h03, 0, H, 0, 1);
    vs(1, 15'd36, 15'd60, 2'b10);
    // 48/48 tie
    frame(1, 8, 12'hF00, 8'hE0, 12'h00F, 8'h03, 0, H, 0, 1);
    vs(1, 15'd48, 15'd48, 2'b00);
    // R=7 below COLOR_MIN, then R=8
    frame(0, 0, 12'h700, 8'h60, 12'h000, 8'h00, 0, H, 0, 1);
    vs(1, 15'd0, 15'd0, 2'b00);
    frame(0, 0, 12'h800, 8'h80, 12'h000, 8'h00, 0, H, 0, 1);
    vs(1, 15'd96, 15'd0, 2'b01);
    // over-long first line with odd byte, plus an extra line beyond HEIGHT
    frame(0, 0, 12'hF00, 8'hE0, 12'h000, 8'h00, 0, H + 1, 1, 1);
    vs(1, 15'd96, 15'd0, 2'b01);
    // short frames: 48 red meets threshold, 32 does not
    frame(0, 0, 12'hF00, 8'hE0, 12'h000, 8'h00, 0, 3, 0, 1);
    vs(1, 15'd48, 15'd0, 2'b01);
    frame(0, 0, 12'hF00, 8'hE0, 12'h000, 8'h00, 0, 2, 0, 1);
    vs(1, 15'd32, 15'd0, 2'b00);

    // mid-frame reset between lines: rest of frame must produce nothing
    frame(0, 0, 12'hF00, 8'hE0, 12'h000, 8'h00, 0, 3, 0, 1);
    @(negedge CLK) RESET_N = 1'b0;
    @(negedge CLK) RESET_N = 1'b1;
    chk_zero("midreset");
    frame(0, 0, 12'hF00, 8'hE0, 12'h000, 8'h00, 3, H, 0, 0);
    vs(0, 0, 0, 2'b00);
    frame(1, 10, 12'hF00, 8'hE0, 12'h00F, 8'h03, 0, H, 0, 1);
    vs(1, 15'd36, 15'd60, 2'b10);

    repeat (10) @(negedge CLK);
    chk("writes_outstanding", wq.size(), 32'd0);
    chk("frames_outstanding", fq.size(), 32'd0);
    chk("result_held", {RED_COUNT, BLUE_COUNT, COLOR_RESULT}, {15'd36, 15'd60, 2'b10});
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
